if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage holding the architectural fetch PC register. It issues one instruction-memory request at a time and presents the fetched instruction plus its PC (`if_pc`) to decode. It sits directly upstream of the next-PC selector: `if_pc` feeds the selector's sequential path, and the selected `npc` comes back here to be loaded into the PC register. Handles decode stalls, redirects (jump/trap) arriving mid-fetch, and misaligned-PC faults.

## Interface
- `RESET_PC`, default 64'h0, PC loaded on reset.
- `NOP_INST`, default 32'h00000013, instruction word presented on fault/reset.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `npc` in 64: next PC from the next-PC selector (if_pc+4, branch target or CSR/trap target).
- `redirect` in 1: `npc` is a non-sequential target (jump_exe | switch_mode); flushes fetch.
- `stall` in 1: decode not accepting; hold the presented instruction.
- `imem_req` out 1: request valid.
- `imem_addr` out 64: request address (= PC register).
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: read data valid. Never in the same cycle as its own `imem_gnt`.
- `imem_rdata` in 32: instruction word.
- `if_valid` out 1: `if_inst`/`if_pc` valid for decode.
- `if_pc` out 64: PC of presented instruction (= PC register).
- `if_inst` out 32: presented instruction.
- `if_fault` out 1: presented PC misaligned (pc[1:0] != 0).

## Operation
- State: PC register `pc_q`, FSM {FETCH, WAIT, HOLD}, `kill` flag, output registers.
- `if_pc` = `imem_addr` = `pc_q` always.
- FETCH:
  - aligned: `imem_req`=1.
  - misaligned: `imem_req`=0. Next cycle HOLD with `if_valid`=1, `if_fault`=1, `if_inst`=NOP_INST.
  - `redirect` without `imem_gnt`: `pc_q`<=`npc`, stay FETCH. Address may change because nothing was accepted.
  - `imem_gnt` without `redirect`: go WAIT, `kill`=0.
  - `imem_gnt` and `redirect` same cycle: `pc_q`<=`npc`, go WAIT, `kill`=1.
- WAIT (one request outstanding, `imem_req`=0):
  - `redirect`: `pc_q`<=`npc`, `kill`<=1.
  - `imem_rvalid` with `kill`=0 and no `redirect` that cycle: `if_inst`<=`imem_rdata`, `if_valid`<=1, `if_fault`<=0, go HOLD.
  - `imem_rvalid` with `kill`=1, or with `redirect` that cycle: discard data, `kill`<=0, go FETCH.
- HOLD (`if_valid`=1):
  - `redirect` (regardless of `stall`): `if_valid`<=0, `if_fault`<=0, `pc_q`<=`npc`, go FETCH.
  - else `stall`=0: instruction consumed; `if_valid`<=0, `pc_q`<=`npc` (sequential if_pc+4), go FETCH.
  - else hold all outputs.
- Priority each cycle: `rst` > `redirect` > `stall` > normal progress.
- PC arithmetic is done by the next-PC selector; `pc_q` loads 64-bit `npc` verbatim. Wrap past 2^64 is the selector's concern and is not checked here.

## Timing
- Reset values: `pc_q`=RESET_PC, state FETCH, `kill`=0, `if_valid`=0, `if_fault`=0, `if_inst`=NOP_INST. `imem_req`=0 in any cycle `rst`=1.
- Best-case latency: gnt in cycle c0, rvalid in c1, `if_valid`=1 in c2.
- Best-case throughput: one instruction per 3 cycles, with no stall.
- `imem_req` held high with stable `imem_addr` until `imem_gnt`, unless `redirect` changes the address.
- `rst` while WAIT drops the outstanding request. Any `imem_rvalid` arriving in FETCH or HOLD after reset is ignored.
- `if_valid` never asserts for data from a request issued before the most recent redirect.

## Test plan
- Reset/sequential: RESET_PC=0x1000, memory returns 0xAAAA0001 and 0xAAAA0002, `npc`=if_pc+4 → `imem_addr` 0x1000 then 0x1004; `if_inst` 0xAAAA0001 then 0xAAAA0002; `if_valid` pulses in cycle 2 after each gnt.
- Stall hold: `stall`=1 for 5 cycles in HOLD at 0x1004 → `if_valid`=1, `if_pc`=0x1004 and `if_inst` constant; no `imem_req` until `stall` drops.
- Redirect in WAIT: gnt at 0x1008, `redirect`=1, `npc`=0x2000 before rvalid → rvalid data discarded, `if_valid` stays 0, next `imem_addr`=0x2000.
- Redirect coincident with gnt and with rvalid: each case → old data never presented; next request goes to the redirect target.
- Misaligned: redirect to 0x2002 → no `imem_req`; next cycle `if_valid`=1, `if_fault`=1, `if_inst`=0x00000013.
- Reset mid-WAIT: `rst`=1 for one cycle while outstanding, then late rvalid → `if_valid`=0, next request at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem request at a
// time and presents the returned word (or a NOP on misaligned PC) to decode.
//
// Handshake rules: a request is transferred in the cycle where imem_req and
// imem_gnt are both high; imem_req stays high with a stable imem_addr until
// then, unless a redirect replaces the address. Exactly one response
// (imem_rvalid) follows each grant, never in the grant cycle. Decode takes
// the presented instruction in a cycle with if_valid=1 and stall=0.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] npc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic        r_kill;
  logic        w_kill_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_fault;
  logic        w_fault_nxt;
  logic [31:0] r_inst;
  logic [31:0] w_inst_nxt;
  logic        w_aligned;
  logic        w_req;

  assign w_aligned = (r_pc[1:0] == 2'b00);
  // A request is only offered from FETCH with an aligned PC and never in reset.
  assign w_req     = (r_state == ST_FETCH) && w_aligned && !rst;

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign if_pc     = r_pc;
  assign if_valid  = r_valid;
  assign if_inst   = r_inst;
  assign if_fault  = r_fault;
  assign dbg_state = r_state;

  // Next-state and next-output logic; redirect outranks stall and progress.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_valid_nxt = r_valid;
    w_fault_nxt = r_fault;
    w_inst_nxt  = r_inst;
    case (r_state)
      ST_FETCH: begin
        if (redirect) begin
          w_pc_nxt = npc;
          // A grant in the redirect cycle leaves a response that must be dropped.
          if (w_req && imem_gnt) begin
            w_state_nxt = ST_WAIT;
            w_kill_nxt  = 1'b1;
          end
        end else if (!w_aligned) begin
          w_state_nxt = ST_HOLD;
          w_valid_nxt = 1'b1;
          w_fault_nxt = 1'b1;
          w_inst_nxt  = NOP_INST;
        end else if (imem_gnt) begin
          w_state_nxt = ST_WAIT;
          w_kill_nxt  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (!r_kill && !redirect) begin
            w_inst_nxt  = imem_rdata;
            w_valid_nxt = 1'b1;
            w_fault_nxt = 1'b0;
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_FETCH;
          end
          w_kill_nxt = 1'b0;
          if (redirect) w_pc_nxt = npc;
        end else if (redirect) begin
          w_pc_nxt   = npc;
          w_kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        // Redirect or consumption both release the slot and load npc.
        if (redirect || !stall) begin
          w_valid_nxt = 1'b0;
          w_fault_nxt = 1'b0;
          w_pc_nxt    = npc;
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_inst  <= NOP_INST;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      r_valid <= w_valid_nxt;
      r_fault <= w_fault_nxt;
      r_inst  <= w_inst_nxt;
    end
  end

endmodule
